// File: rtl/debug_mem_dump_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : debug_mem_dump_if                                        |
// | Brief   : Memory debug read port plus UART TX byte handshake        |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface debug_mem_dump_if #(
   parameter int NUM_BITS  = 32,
   parameter int NUM_DIREC = 7
);
   logic [NUM_DIREC-1:0] o_direcc_debug;
   logic [NUM_BITS-1:0]  i_data_debug;
   logic [7:0]           o_tx_data;
   logic                 o_tx_start;
   logic                 i_tx_done;

   // Dump engine side: drives the address and the byte to transmit
   modport master (
      output o_direcc_debug,
      output o_tx_data,
      output o_tx_start,
      input  i_data_debug,
      input  i_tx_done
   );

   // Memory / UART side
   modport slave (
      input  o_direcc_debug,
      input  o_tx_data,
      input  o_tx_start,
      output i_data_debug,
      output i_tx_done
   );
endinterface
`default_nettype wire

// File: rtl/debug_mem_dump.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : debug_mem_dump                                           |
// | Brief   : Walks the data memory through its debug port and streams  |
// |           every byte, little-endian per word, into the UART TX     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module debug_mem_dump #(
   parameter int NUM_BITS  = 32,
   parameter int NUM_SLOTS = 128,
   parameter int NUM_DIREC = $clog2(NUM_SLOTS)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   debug_mem_dump_if.master  bus,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [NUM_DIREC-1:0] LAST_ADDR = NUM_DIREC'(NUM_SLOTS - 4);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_RD = 3'd1,
      S_SEND    = 3'd2,
      S_WAIT_TX = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state_q;
   logic [NUM_DIREC-1:0] addr_q;
   logic [1:0]           idx_q;
   logic [NUM_BITS-1:0]  word_q;
   logic [7:0]           tx_data_q;
   logic                 tx_start_q;
   logic                 busy_q;
   logic                 done_q;

   logic [1:0]           idx_d;
   logic [7:0]           next_byte_d;

   // Byte of the captured word that follows the one currently on the wire
   always_comb begin
      idx_d = idx_q + 2'd1;
      next_byte_d = word_q[7:0];
      case (idx_d)
         2'd0:    next_byte_d = word_q[7:0];
         2'd1:    next_byte_d = word_q[15:8];
         2'd2:    next_byte_d = word_q[23:16];
         default: next_byte_d = word_q[31:24];
      endcase
   end

   // Dump sequencer; every output is a register updated with the state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         idx_q      <= 2'd0;
         word_q     <= '0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  addr_q  <= '0;
                  idx_q   <= 2'd0;
                  busy_q  <= 1'b1;
                  state_q <= S_WAIT_RD;
               end
            end
            S_WAIT_RD: begin
               // Memory word is valid now; byte 0 goes out straight from it
               word_q     <= i_data_debug_w();
               tx_data_q  <= bus.i_data_debug[7:0];
               tx_start_q <= 1'b1;
               state_q    <= S_SEND;
            end
            S_SEND: begin
               state_q <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (bus.i_tx_done) begin
                  if (idx_q != 2'd3) begin
                     idx_q      <= idx_d;
                     tx_data_q  <= next_byte_d;
                     tx_start_q <= 1'b1;
                     state_q    <= S_SEND;
                  end else if (addr_q == LAST_ADDR) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     addr_q  <= addr_q + NUM_DIREC'(4);
                     idx_q   <= 2'd0;
                     state_q <= S_WAIT_RD;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   function automatic logic [NUM_BITS-1:0] i_data_debug_w();
      return bus.i_data_debug;
   endfunction

   assign bus.o_direcc_debug = addr_q;
   assign bus.o_tx_data      = tx_data_q;
   assign bus.o_tx_start     = tx_start_q;
   assign o_busy             = busy_q;
   assign o_done             = done_q;

endmodule
`default_nettype wire
